// File: rtl/lpif_rxfifo_x8_asym1_half_master.sv
// Receive-side elastic buffer between the link receive channel and the LPIF unpacker.
// Optional build macro LPIF_RXFIFO_WORDCNT_EN adds the rx_word_cnt accepted-push counter.
//
// state  | meaning
// IDLE   | link down; pushes ignored, pointers/level at 0, idle word on output
// FILL   | pushes accepted, no pops, until level reaches START_LEVEL
// STREAM | pushes and pops active; running dry flags underflow but stays here
module lpif_rxfifo_x8_asym1_half_master #(
  parameter int WIDTH       = 546,
  parameter int DEPTH       = 8,
  parameter int START_LEVEL = 2,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic             clk_wr,
  input  logic             rst_wr_n,
  input  logic             rx_online,
  input  logic             rxfifo_push_vld,
  input  logic [WIDTH-1:0] rxfifo_push_data,
  input  logic             rxfifo_pop_ready,
  output logic [WIDTH-1:0] rxfifo_upstream_data,
  output logic             rxfifo_upstream_vld,
  output logic [AW:0]      fifo_level,
  output logic             fifo_overflow,
  output logic             fifo_underflow,
`ifdef LPIF_RXFIFO_WORDCNT_EN
  output logic [15:0]      rx_word_cnt,
`endif
  input  logic             err_clr
);

  localparam logic [AW:0] LVL_FULL  = (AW+1)'(DEPTH);
  localparam logic [AW:0] LVL_START = (AW+1)'(START_LEVEL);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_STREAM} state_t;

  state_t           state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             pop;
  logic             push_ok;
  logic             push_drop;
  logic             run_dry;

  // Link-down cycles discard any in-flight push/pop, so everything is gated by rx_online.
  always_comb begin
    pop       = rx_online && (state == S_STREAM) && rxfifo_pop_ready && (fifo_level != '0);
    push_ok   = rx_online && (state != S_IDLE) && rxfifo_push_vld &&
                ((fifo_level != LVL_FULL) || pop);
    push_drop = rx_online && (state != S_IDLE) && rxfifo_push_vld && !push_ok;
    run_dry   = rx_online && (state == S_STREAM) && rxfifo_pop_ready && (fifo_level == '0);
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk_wr) begin
    if (push_ok) mem[wr_ptr] <= rxfifo_push_data;
  end

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      state                <= S_IDLE;
      wr_ptr               <= '0;
      rd_ptr               <= '0;
      fifo_level           <= '0;
      rxfifo_upstream_data <= '0;
      rxfifo_upstream_vld  <= 1'b0;
    end else if (!rx_online) begin
      state                <= S_IDLE;
      wr_ptr               <= '0;
      rd_ptr               <= '0;
      fifo_level           <= '0;
      rxfifo_upstream_data <= '0;
      rxfifo_upstream_vld  <= 1'b0;
    end else begin
      case (state)
        S_IDLE:  state <= S_FILL;
        S_FILL:  if (fifo_level >= LVL_START) state <= S_STREAM;
        default: state <= S_STREAM;
      endcase

      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;

      if (push_ok && !pop)      fifo_level <= fifo_level + 1'b1;
      else if (pop && !push_ok) fifo_level <= fifo_level - 1'b1;

      // All-zero word carries dvalid/valid = 0 to the unpacker.
      if (pop) begin
        rxfifo_upstream_data <= mem[rd_ptr];
        rxfifo_upstream_vld  <= 1'b1;
      end else if (rxfifo_pop_ready) begin
        rxfifo_upstream_data <= '0;
        rxfifo_upstream_vld  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      fifo_overflow  <= 1'b0;
      fifo_underflow <= 1'b0;
    end else begin
      if (push_drop)    fifo_overflow <= 1'b1;
      else if (err_clr) fifo_overflow <= 1'b0;
      if (run_dry)      fifo_underflow <= 1'b1;
      else if (err_clr) fifo_underflow <= 1'b0;
    end
  end

`ifdef LPIF_RXFIFO_WORDCNT_EN
  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      rx_word_cnt <= '0;
    end else if (!rx_online || err_clr) begin
      rx_word_cnt <= '0;
    end else if (push_ok && (rx_word_cnt != 16'hFFFF)) begin
      rx_word_cnt <= rx_word_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_lpif_rxfifo_x8_asym1_half_master.sv
// Directed bench for lpif_rxfifo_x8_asym1_half_master (DEPTH=8, START_LEVEL=2).
module tb_lpif_rxfifo_x8_asym1_half_master;
  localparam int WIDTH = 546;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic             clk_wr = 1'b0;
  logic             rst_wr_n;
  logic             rx_online;
  logic             rxfifo_push_vld;
  logic [WIDTH-1:0] rxfifo_push_data;
  logic             rxfifo_pop_ready;
  logic [WIDTH-1:0] rxfifo_upstream_data;
  logic             rxfifo_upstream_vld;
  logic [AW:0]      fifo_level;
  logic             fifo_overflow;
  logic             fifo_underflow;
  logic             err_clr;
`ifdef LPIF_RXFIFO_WORDCNT_EN
  logic [15:0]      rx_word_cnt;
`endif

  int total = 0;
  int bad   = 0;

  lpif_rxfifo_x8_asym1_half_master #(.WIDTH(WIDTH), .DEPTH(DEPTH), .START_LEVEL(2)) dut (
    .clk_wr               (clk_wr),
    .rst_wr_n             (rst_wr_n),
    .rx_online            (rx_online),
    .rxfifo_push_vld      (rxfifo_push_vld),
    .rxfifo_push_data     (rxfifo_push_data),
    .rxfifo_pop_ready     (rxfifo_pop_ready),
    .rxfifo_upstream_data (rxfifo_upstream_data),
    .rxfifo_upstream_vld  (rxfifo_upstream_vld),
    .fifo_level           (fifo_level),
    .fifo_overflow        (fifo_overflow),
    .fifo_underflow       (fifo_underflow),
`ifdef LPIF_RXFIFO_WORDCNT_EN
    .rx_word_cnt          (rx_word_cnt),
`endif
    .err_clr              (err_clr)
  );

  always #5 clk_wr = ~clk_wr;

  function automatic logic [WIDTH-1:0] mk(input int i);
    logic [WIDTH-1:0] w;
    w = '0;
    w[31:0]    = 32'hC0DE_0000 + 32'(i);
    w[544:513] = ~(32'(i));
    w[272]     = 1'b1;
    w[545]     = 1'b1;
    return w;
  endfunction

  task automatic step();
    @(posedge clk_wr);
    #1;
  endtask

  task automatic test_reset();
    rst_wr_n = 1'b0; rx_online = 1'b0; rxfifo_push_vld = 1'b0; rxfifo_push_data = '0;
    rxfifo_pop_ready = 1'b0; err_clr = 1'b0;
    step(); step();
    total++; if (rxfifo_upstream_vld !== 1'b0) begin bad++; $display("FAIL rst_vld got=%b exp=0", rxfifo_upstream_vld); end
    total++; if (fifo_level !== 4'd0) begin bad++; $display("FAIL rst_level got=%0d exp=0", fifo_level); end
    rst_wr_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rxfifo_push_vld = 1'b1; rxfifo_push_data = mk(i);
      step();
    end
    rxfifo_push_vld = 1'b0;
    total++; if (fifo_level !== 4'd0) begin bad++; $display("FAIL idle_level got=%0d exp=0", fifo_level); end
    total++; if (rxfifo_upstream_vld !== 1'b0) begin bad++; $display("FAIL idle_vld got=%b exp=0", rxfifo_upstream_vld); end
    total++; if (rxfifo_upstream_data !== '0) begin bad++; $display("FAIL idle_data got=%h exp=0", rxfifo_upstream_data); end
    total++; if ({fifo_overflow, fifo_underflow} !== 2'b00) begin bad++; $display("FAIL idle_flags got=%b exp=00", {fifo_overflow, fifo_underflow}); end
  endtask

  task automatic test_start_threshold();
    rx_online = 1'b1; rxfifo_pop_ready = 1'b1;
    step();                                   // IDLE -> FILL
    rxfifo_push_vld = 1'b1; rxfifo_push_data = mk(0);
    step();
    total++; if (fifo_level !== 4'd1) begin bad++; $display("FAIL fill_level1 got=%0d exp=1", fifo_level); end
    rxfifo_push_data = mk(1);
    step();
    rxfifo_push_vld = 1'b0;
    total++; if (rxfifo_upstream_vld !== 1'b0) begin bad++; $display("FAIL fill_no_pop got=%b exp=0", rxfifo_upstream_vld); end
    step();                                   // FILL -> STREAM
    total++; if (fifo_level !== 4'd2) begin bad++; $display("FAIL fill_level2 got=%0d exp=2", fifo_level); end
    step();
    total++; if (rxfifo_upstream_data !== mk(0) || rxfifo_upstream_vld !== 1'b1) begin bad++; $display("FAIL start_w0 got=%h/%b exp=%h/1", rxfifo_upstream_data, rxfifo_upstream_vld, mk(0)); end
    total++; if (fifo_level !== 4'd1) begin bad++; $display("FAIL start_level1 got=%0d exp=1", fifo_level); end
    step();
    rxfifo_pop_ready = 1'b0;
    total++; if (rxfifo_upstream_data !== mk(1) || rxfifo_upstream_vld !== 1'b1) begin bad++; $display("FAIL start_w1 got=%h/%b exp=%h/1", rxfifo_upstream_data, rxfifo_upstream_vld, mk(1)); end
    total++; if (fifo_level !== 4'd0) begin bad++; $display("FAIL start_level0 got=%0d exp=0", fifo_level); end
    step();
    total++; if (fifo_underflow !== 1'b0) begin bad++; $display("FAIL start_underflow got=%b exp=0", fifo_underflow); end
    total++; if (rxfifo_upstream_data !== mk(1)) begin bad++; $display("FAIL start_hold got=%h exp=%h", rxfifo_upstream_data, mk(1)); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 9; i++) begin
      rxfifo_push_vld = 1'b1; rxfifo_push_data = mk(10 + i);
      step();
      if (i == 7) begin
        total++; if (fifo_overflow !== 1'b0) begin bad++; $display("FAIL ovf_early got=%b exp=0", fifo_overflow); end
      end
    end
    rxfifo_push_vld = 1'b0;
    total++; if (fifo_level !== 4'd8) begin bad++; $display("FAIL ovf_level got=%0d exp=8", fifo_level); end
    total++; if (fifo_overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", fifo_overflow); end
    rxfifo_pop_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      if (k == 7) rxfifo_pop_ready = 1'b0;
      total++; if (rxfifo_upstream_data !== mk(10 + k) || rxfifo_upstream_vld !== 1'b1) begin bad++; $display("FAIL ovf_pop%0d got=%h/%b exp=%h/1", k, rxfifo_upstream_data, rxfifo_upstream_vld, mk(10 + k)); end
    end
    total++; if (fifo_level !== 4'd0) begin bad++; $display("FAIL ovf_drained got=%0d exp=0", fifo_level); end
    err_clr = 1'b1; step(); err_clr = 1'b0;
    total++; if (fifo_overflow !== 1'b0) begin bad++; $display("FAIL ovf_clr got=%b exp=0", fifo_overflow); end
  endtask

  task automatic test_underflow();
    rxfifo_pop_ready = 1'b1;
    step();
    rxfifo_pop_ready = 1'b0;
    total++; if (fifo_underflow !== 1'b1) begin bad++; $display("FAIL unf_flag got=%b exp=1", fifo_underflow); end
    total++; if (rxfifo_upstream_data !== '0 || rxfifo_upstream_vld !== 1'b0) begin bad++; $display("FAIL unf_idle got=%h/%b exp=0/0", rxfifo_upstream_data, rxfifo_upstream_vld); end
    err_clr = 1'b1; rxfifo_pop_ready = 1'b1;
    step();
    rxfifo_pop_ready = 1'b0;
    total++; if (fifo_underflow !== 1'b1) begin bad++; $display("FAIL unf_set_wins got=%b exp=1", fifo_underflow); end
    step();
    err_clr = 1'b0;
    total++; if (fifo_underflow !== 1'b0) begin bad++; $display("FAIL unf_clr got=%b exp=0", fifo_underflow); end
    for (int i = 0; i < 8; i++) begin
      rxfifo_push_vld = 1'b1; rxfifo_push_data = mk(20 + i);
      step();
    end
    total++; if (fifo_level !== 4'd8) begin bad++; $display("FAIL full_level got=%0d exp=8", fifo_level); end
    rxfifo_push_data = mk(28); rxfifo_pop_ready = 1'b1;
    step();
    rxfifo_push_vld = 1'b0;
    total++; if (fifo_level !== 4'd8) begin bad++; $display("FAIL fullpop_level got=%0d exp=8", fifo_level); end
    total++; if (fifo_overflow !== 1'b0) begin bad++; $display("FAIL fullpop_ovf got=%b exp=0", fifo_overflow); end
    total++; if (rxfifo_upstream_data !== mk(20)) begin bad++; $display("FAIL fullpop_data got=%h exp=%h", rxfifo_upstream_data, mk(20)); end
    for (int k = 0; k < 8; k++) begin
      step();
      if (k == 7) rxfifo_pop_ready = 1'b0;
      total++; if (rxfifo_upstream_data !== mk(21 + k)) begin bad++; $display("FAIL fullpop_drain%0d got=%h exp=%h", k, rxfifo_upstream_data, mk(21 + k)); end
    end
    total++; if (fifo_level !== 4'd0 || fifo_underflow !== 1'b0) begin bad++; $display("FAIL fullpop_end got=%0d/%b exp=0/0", fifo_level, fifo_underflow); end
  endtask

  task automatic test_link_drop();
    for (int i = 0; i < 5; i++) begin
      rxfifo_push_vld = 1'b1; rxfifo_push_data = mk(30 + i);
      step();
    end
    total++; if (fifo_level !== 4'd5 || rxfifo_upstream_vld !== 1'b1) begin bad++; $display("FAIL drop_pre got=%0d/%b exp=5/1", fifo_level, rxfifo_upstream_vld); end
    rx_online = 1'b0; rxfifo_push_data = mk(35);
    step();
    rxfifo_push_vld = 1'b0;
    total++; if (fifo_level !== 4'd0) begin bad++; $display("FAIL drop_level got=%0d exp=0", fifo_level); end
    total++; if (rxfifo_upstream_vld !== 1'b0 || rxfifo_upstream_data !== '0) begin bad++; $display("FAIL drop_out got=%h/%b exp=0/0", rxfifo_upstream_data, rxfifo_upstream_vld); end
    rx_online = 1'b1;
    step();                                   // IDLE -> FILL
    rxfifo_push_vld = 1'b1; rxfifo_push_data = mk(40); step();
    rxfifo_push_data = mk(41); step();
    rxfifo_push_vld = 1'b0;
    step();                                   // FILL -> STREAM
    rxfifo_pop_ready = 1'b1;
    step();
    total++; if (rxfifo_upstream_data !== mk(40) || rxfifo_upstream_vld !== 1'b1) begin bad++; $display("FAIL relink_first got=%h/%b exp=%h/1", rxfifo_upstream_data, rxfifo_upstream_vld, mk(40)); end
    step();
    rxfifo_pop_ready = 1'b0;
    total++; if (rxfifo_upstream_data !== mk(41)) begin bad++; $display("FAIL relink_second got=%h exp=%h", rxfifo_upstream_data, mk(41)); end
`ifdef LPIF_RXFIFO_WORDCNT_EN
    total++; if (rx_word_cnt !== 16'd2) begin bad++; $display("FAIL relink_wordcnt got=%0d exp=2", rx_word_cnt); end
`endif
  endtask

  task automatic test_wrap();
    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] exp_w;
    logic p, r;
    int sent, got, lvl;
    sent = 0; got = 0; lvl = 0;
    err_clr = 1'b1; step(); err_clr = 1'b0;
    for (int cyc = 0; cyc < 300 && got < 20; cyc++) begin
      p = (sent < 20) && (lvl < DEPTH) && ($urandom_range(0, 2) != 0);
      r = (lvl > 0) && ($urandom_range(0, 1) == 1);
      rxfifo_push_vld = p; rxfifo_push_data = mk(100 + sent); rxfifo_pop_ready = r;
      step();
      if (p) begin q.push_back(mk(100 + sent)); sent++; lvl++; end
      if (r) begin
        exp_w = q.pop_front(); lvl--; got++;
        total++; if (rxfifo_upstream_data !== exp_w || rxfifo_upstream_vld !== 1'b1) begin bad++; $display("FAIL wrap_word%0d got=%h/%b exp=%h/1", got, rxfifo_upstream_data, rxfifo_upstream_vld, exp_w); end
      end
      total++; if (fifo_level !== 4'(lvl)) begin bad++; $display("FAIL wrap_level cyc=%0d got=%0d exp=%0d", cyc, fifo_level, lvl); end
    end
    rxfifo_push_vld = 1'b0; rxfifo_pop_ready = 1'b0;
    total++; if (got != 20) begin bad++; $display("FAIL wrap_count got=%0d exp=20", got); end
    total++; if ({fifo_overflow, fifo_underflow} !== 2'b00) begin bad++; $display("FAIL wrap_flags got=%b exp=00", {fifo_overflow, fifo_underflow}); end
`ifdef LPIF_RXFIFO_WORDCNT_EN
    total++; if (rx_word_cnt !== 16'd20) begin bad++; $display("FAIL wrap_wordcnt got=%0d exp=20", rx_word_cnt); end
`endif
  endtask

  initial begin
    test_reset();
    test_start_threshold();
    test_overflow();
    test_underflow();
    test_link_drop();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
